// File: rtl/fnd_scan_driver.sv
// Four-digit common-anode 7-segment scan driver. It snapshots the time fields once per frame
// and rotates digit enables on a prescaled tick.
module fnd_scan_driver #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_mode,
    input  logic [6:0] msec,
    input  logic [6:0] sec,
    input  logic [6:0] min,
    input  logic [4:0] hour,
    output logic [3:0] fnd_comm,
    output logic [7:0] fnd_font
);

    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          tick;
    logic [1:0]    sel;
    logic [1:0]    sel_next;
    logic          frame_edge;

    logic          snap_mode;
    logic [6:0]    snap_msec;
    logic [6:0]    snap_sec;
    logic [6:0]    snap_min;
    logic [4:0]    snap_hour;

    logic          nx_mode;
    logic [6:0]    nx_msec;
    logic [6:0]    nx_sec;
    logic [6:0]    nx_min;
    logic [4:0]    nx_hour;

    logic [6:0]    field;
    logic [3:0]    digit;
    logic [7:0]    font_next;

    assign tick       = (cnt == LAST);
    assign sel_next   = sel + 2'd1;
    assign frame_edge = tick && (sel == 2'd3);

    // Digit 0 of a new frame is encoded on the same edge the snapshot is taken,
    // so the encoder looks through to the inputs at that edge.
    assign nx_mode = frame_edge ? sw_mode : snap_mode;
    assign nx_msec = frame_edge ? msec    : snap_msec;
    assign nx_sec  = frame_edge ? sec     : snap_sec;
    assign nx_min  = frame_edge ? min     : snap_min;
    assign nx_hour = frame_edge ? hour    : snap_hour;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    always_comb begin
        field     = 7'd0;
        digit     = 4'd0;
        font_next = 8'hFF;
        if (sel_next[1])
            field = nx_mode ? {2'b00, nx_hour} : nx_sec;
        else
            field = nx_mode ? nx_min : nx_msec;
        digit     = sel_next[0] ? 4'(field / 7'd10) : 4'(field % 7'd10);
        font_next = (field >= 7'd100) ? 8'hBF : seg7(digit);
        // Separator dot blinks with the centisecond half-second.
        if (sel_next == 2'd2 && nx_msec < 7'd50)
            font_next[7] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            sel       <= 2'd0;
            snap_mode <= 1'b0;
            snap_msec <= 7'd0;
            snap_sec  <= 7'd0;
            snap_min  <= 7'd0;
            snap_hour <= 5'd0;
            fnd_comm  <= 4'b1111;
            fnd_font  <= 8'hFF;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                sel      <= sel_next;
                fnd_comm <= ~(4'b0001 << sel_next);
                fnd_font <= font_next;
            end
            if (frame_edge) begin
                snap_mode <= sw_mode;
                snap_msec <= msec;
                snap_sec  <= sec;
                snap_min  <= min;
                snap_hour <= hour;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver at DIV=10: frame vector table plus reset,
// snapshot-isolation, mode-switch and rotation-period sequences.
module tb_fnd_scan_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sw_mode = 1'b0;
    logic [6:0] msec = 7'd0;
    logic [6:0] sec = 7'd0;
    logic [6:0] min = 7'd0;
    logic [4:0] hour = 5'd0;
    logic [3:0] fnd_comm;
    logic [7:0] fnd_font;

    int checks = 0;
    int failures = 0;

    fnd_scan_driver #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
        .clk(clk), .reset(reset), .sw_mode(sw_mode), .msec(msec), .sec(sec),
        .min(min), .hour(hour), .fnd_comm(fnd_comm), .fnd_font(fnd_font)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [6:0]  ms;
        logic [6:0]  s;
        logic [6:0]  m;
        logic [4:0]  h;
        logic [31:0] fonts;   // {d3, d2, d1, d0}
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_comm(input string name, input logic [3:0] target);
        int n = 0;
        while (fnd_comm !== target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, fnd_comm, target);
    endtask

    task automatic wait_comm_not(input string name, input logic [3:0] target);
        int n = 0;
        while (fnd_comm === target && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {3'b0, fnd_comm !== target}, 32'd1);
    endtask

    // Waits for a frame whose snapshot postdates the current inputs, then checks all four digits.
    task automatic run_frame(input string tag, input logic [31:0] exp);
        logic [3:0] ec;
        wait_comm_not({tag, "_sync_leave"}, 4'b1110);
        wait_comm({tag, "_sync_frame"}, 4'b1110);
        for (int d = 0; d < 4; d++) begin
            ec = 4'b1111;
            ec[d] = 1'b0;
            chk($sformatf("%s_comm%0d", tag, d), fnd_comm, ec);
            chk($sformatf("%s_font%0d", tag, d), fnd_font, exp[8*d +: 8]);
            if (d < 3) step(10);
        end
    endtask

    task automatic set_in(input logic mo, input logic [6:0] ms, input logic [6:0] s,
                          input logic [6:0] m, input logic [4:0] h);
        sw_mode = mo; msec = ms; sec = s; min = m; hour = h;
    endtask

    initial begin
        vecs[0] = '{1'b0, 7'd42,  7'd37,  7'd0,   5'd0,  {8'hB0, 8'h78, 8'h99, 8'hA4}};
        vecs[1] = '{1'b1, 7'd75,  7'd0,   7'd5,   5'd23, {8'hA4, 8'hB0, 8'hC0, 8'h92}};
        vecs[2] = '{1'b0, 7'd127, 7'd37,  7'd0,   5'd0,  {8'hB0, 8'hF8, 8'hBF, 8'hBF}};
        vecs[3] = '{1'b0, 7'd99,  7'd59,  7'd0,   5'd0,  {8'h92, 8'h90, 8'h90, 8'h90}};
        vecs[4] = '{1'b0, 7'd49,  7'd0,   7'd0,   5'd0,  {8'hC0, 8'h40, 8'h99, 8'h90}};
        vecs[5] = '{1'b0, 7'd50,  7'd100, 7'd0,   5'd0,  {8'hBF, 8'hBF, 8'h92, 8'hC0}};
        vecs[6] = '{1'b0, 7'd0,   7'd120, 7'd0,   5'd0,  {8'hBF, 8'h3F, 8'hC0, 8'hC0}};
        vecs[7] = '{1'b1, 7'd10,  7'd0,   7'd127, 5'd0,  {8'hC0, 8'h40, 8'hBF, 8'hBF}};
        vecs[8] = '{1'b1, 7'd60,  7'd0,   7'd48,  5'd19, {8'hF9, 8'h90, 8'h99, 8'h80}};

        // Reset and first-tick latency
        #2 reset = 1'b1;
        #1;
        chk("rst_comm", fnd_comm, 4'b1111);
        chk("rst_font", fnd_font, 8'hFF);
        step(2);
        reset = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk($sformatf("pre_tick_comm_%0d", i), fnd_comm, 4'b1111);
            chk($sformatf("pre_tick_font_%0d", i), fnd_font, 8'hFF);
        end
        @(negedge clk);
        chk("first_comm", fnd_comm, 4'b1101);
        chk("first_font", fnd_font, 8'hC0);

        // Asynchronous reset between clock edges
        step(12);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_comm", fnd_comm, 4'b1111);
        chk("async_rst_font", fnd_font, 8'hFF);
        @(negedge clk);
        reset = 1'b0;
        step(9);
        chk("rerst_pre_comm", fnd_comm, 4'b1111);
        step(1);
        chk("rerst_first_comm", fnd_comm, 4'b1101);

        // Frame vector table
        foreach (vecs[i]) begin
            set_in(vecs[i].mode, vecs[i].ms, vecs[i].s, vecs[i].m, vecs[i].h);
            run_frame($sformatf("vec%0d", i), vecs[i].fonts);
        end

        // Out-of-range digits keep rotating with a 40-clk frame period
        set_in(1'b0, 7'd127, 7'd37, 7'd0, 5'd0);
        run_frame("oor", {8'hB0, 8'hF8, 8'hBF, 8'hBF});
        step(10);
        chk("oor_period_comm", fnd_comm, 4'b1110);
        chk("oor_period_font", fnd_font, 8'hBF);

        // Input change mid-frame is not visible until the next frame
        set_in(1'b0, 7'd10, 7'd12, 7'd0, 5'd0);
        run_frame("iso_pre", {8'hF9, 8'h24, 8'hF9, 8'hC0});
        wait_comm("iso_sync", 4'b1101);
        sec = 7'd34;
        step(10); chk("iso_d2_old", fnd_font, 8'h24);
        step(10); chk("iso_d3_old", fnd_font, 8'hF9);
        step(10); chk("iso_d0_new", fnd_font, 8'hC0);
        step(10); chk("iso_d1_new", fnd_font, 8'hF9);
        step(10); chk("iso_d2_new", fnd_font, 8'h19);
        step(10); chk("iso_d3_new", fnd_font, 8'hB0);

        // Mode switch mid-frame takes effect at the next frame boundary
        set_in(1'b0, 7'd42, 7'd37, 7'd5, 5'd23);
        run_frame("mode_pre", {8'hB0, 8'h78, 8'h99, 8'hA4});
        wait_comm("mode_sync", 4'b1011);
        sw_mode = 1'b1;
        step(10); chk("mode_d3_old", fnd_font, 8'hB0);
        step(10); chk("mode_d0_new", fnd_font, 8'h92);
        step(10); chk("mode_d1_new", fnd_font, 8'hC0);
        step(10); chk("mode_d2_new", fnd_font, 8'h30);
        step(10); chk("mode_d3_new", fnd_font, 8'hA4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
